// File: rtl/camera_top.sv
// camera_top: OV7670 register-table writer over SCCB (table sequencer + byte-level I2C write engine).
// Define ACK_CHECK_EN to sample ACK slots, abort on NACK and expose the err output.

module cam_i2c_wr #(
    parameter int Q = 250
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       go_i,
    input  logic [7:0] dev_i,
    input  logic [7:0] reg_i,
    input  logic [7:0] data_i,
`ifdef ACK_CHECK_EN
    input  logic       sda_i,
    output logic       nack_o,
`endif
    output logic       sda_pull_o,
    output logic       scl_pull_o,
    output logic       done
);
    localparam int QW = (Q > 1) ? $clog2(Q) : 1;

    typedef enum logic [1:0] {E_IDLE, E_START, E_BIT, E_STOP} eng_t;

    eng_t          est_q, est_d;
    logic [QW-1:0] qcnt_q, qcnt_d;
    logic [1:0]    ph_q, ph_d;
    logic [4:0]    bit_q, bit_d;
    logic [26:0]   frame_q, frame_d;
    logic          tick;

    assign tick = (qcnt_q == QW'(Q - 1));

`ifdef ACK_CHECK_EN
    logic nack_q, nack_d;
    logic ack_slot;
    assign ack_slot = (bit_q == 5'd8) || (bit_q == 5'd17) || (bit_q == 5'd26);
    assign nack_o   = nack_q;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            est_q  <= E_IDLE;
            qcnt_q <= '0;
            ph_q   <= '0;
            bit_q  <= '0;
`ifdef ACK_CHECK_EN
            nack_q <= 1'b0;
`endif
        end else begin
            est_q  <= est_d;
            qcnt_q <= qcnt_d;
            ph_q   <= ph_d;
            bit_q  <= bit_d;
`ifdef ACK_CHECK_EN
            nack_q <= nack_d;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        frame_q <= frame_d;
    end

    // Each engine state spans whole bit periods of four quarter ticks (phases 0..3).
    always_comb begin
        est_d      = est_q;
        qcnt_d     = (est_q == E_IDLE || tick) ? '0 : qcnt_q + QW'(1);
        ph_d       = ph_q;
        bit_d      = bit_q;
        frame_d    = frame_q;
        sda_pull_o = 1'b0;
        scl_pull_o = 1'b0;
        done       = 1'b0;
`ifdef ACK_CHECK_EN
        nack_d     = nack_q;
`endif
        case (est_q)
            E_IDLE: begin
                if (go_i) begin
                    est_d   = E_START;
                    ph_d    = 2'd0;
                    bit_d   = 5'd0;
                    // Ones in the ACK slots leave SDA released for the slave.
                    frame_d = {dev_i, 1'b1, reg_i, 1'b1, data_i, 1'b1};
`ifdef ACK_CHECK_EN
                    nack_d  = 1'b0;
`endif
                end
            end
            E_START: begin
                sda_pull_o = (ph_q != 2'd0);
                scl_pull_o = (ph_q == 2'd3);
                if (tick) begin
                    ph_d = ph_q + 2'd1;
                    if (ph_q == 2'd3) est_d = E_BIT;
                end
            end
            E_BIT: begin
                sda_pull_o = ~frame_q[26];
                scl_pull_o = (ph_q == 2'd0) || (ph_q == 2'd3);
                if (tick) begin
                    ph_d = ph_q + 2'd1;
`ifdef ACK_CHECK_EN
                    if (ph_q == 2'd2 && ack_slot && sda_i) nack_d = 1'b1;
`endif
                    if (ph_q == 2'd3) begin
                        frame_d = {frame_q[25:0], 1'b1};
                        bit_d   = bit_q + 5'd1;
                        if (bit_q == 5'd26) est_d = E_STOP;
`ifdef ACK_CHECK_EN
                        if (ack_slot && nack_q) est_d = E_STOP;
`endif
                    end
                end
            end
            E_STOP: begin
                sda_pull_o = (ph_q < 2'd2);
                scl_pull_o = (ph_q == 2'd0);
                if (tick) begin
                    ph_d = ph_q + 2'd1;
                    if (ph_q == 2'd3) begin
                        est_d = E_IDLE;
                        done  = 1'b1;
                    end
                end
            end
            default: est_d = E_IDLE;
        endcase
    end
endmodule

module camera_top #(
    parameter int         CLK_FREQ_HZ = 100000000,
    parameter int         SCL_FREQ_HZ = 100000,
    parameter logic [7:0] DEV_ADDR    = 8'h42,
    parameter int         NUM_REGS    = 4,
    parameter int         GAP_CYCLES  = 1000
) (
    input  logic Clk,
    input  logic reset,
    input  logic start,
    inout  wire  sda,
    output wire  scl,
    output logic done,
    output logic busy
`ifdef ACK_CHECK_EN
    ,
    output logic err
`endif
);
    localparam int Q  = CLK_FREQ_HZ / (4 * SCL_FREQ_HZ);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_XFER, S_GAP, S_DONE} seq_t;

    seq_t          seq_q, seq_d;
    logic [7:0]    idx_q, idx_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          start_q;
    logic          start_rise;
    logic          go;
    logic          eng_done;
    logic          sda_pull, scl_pull;
    logic [15:0]   entry;

    function automatic logic [15:0] table_entry(input logic [7:0] i);
        case (i)
            8'd0:    table_entry = 16'h1280;
            8'd1:    table_entry = 16'h1204;
            8'd2:    table_entry = 16'h40D0;
            8'd3:    table_entry = 16'h1101;
            default: table_entry = 16'hFFFF;
        endcase
    endfunction

    assign entry      = table_entry(idx_q);
    assign start_rise = start & ~start_q;

`ifdef ACK_CHECK_EN
    logic err_q, err_d;
    logic eng_nack;
    assign err = err_q;
`endif

    cam_i2c_wr #(
        .Q(Q)
    ) i2c_inst (
        .clk_i      (Clk),
        .rst_i      (reset),
        .go_i       (go),
        .dev_i      (DEV_ADDR),
        .reg_i      (entry[15:8]),
        .data_i     (entry[7:0]),
`ifdef ACK_CHECK_EN
        .sda_i      (sda),
        .nack_o     (eng_nack),
`endif
        .sda_pull_o (sda_pull),
        .scl_pull_o (scl_pull),
        .done       (eng_done)
    );

    assign sda  = sda_pull ? 1'b0 : 1'bz;
    assign scl  = scl_pull ? 1'b0 : 1'bz;
    assign done = (seq_q == S_DONE);
    assign busy = (seq_q == S_START) || (seq_q == S_XFER) || (seq_q == S_GAP);

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            seq_q   <= S_IDLE;
            idx_q   <= '0;
            gap_q   <= '0;
            start_q <= 1'b0;
`ifdef ACK_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            seq_q   <= seq_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            start_q <= start;
`ifdef ACK_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        seq_d = seq_q;
        idx_d = idx_q;
        gap_d = gap_q;
        go    = 1'b0;
`ifdef ACK_CHECK_EN
        err_d = err_q;
`endif
        case (seq_q)
            S_IDLE, S_DONE: begin
                if (start_rise) begin
                    seq_d = S_START;
                    idx_d = '0;
`ifdef ACK_CHECK_EN
                    err_d = 1'b0;
`endif
                end
            end
            S_START: begin
                go    = 1'b1;
                seq_d = S_XFER;
            end
            S_XFER: begin
                if (eng_done) begin
                    seq_d = S_GAP;
                    gap_d = '0;
`ifdef ACK_CHECK_EN
                    if (eng_nack) begin
                        seq_d = S_DONE;
                        err_d = 1'b1;
                    end
`endif
                end
            end
            S_GAP: begin
                if (gap_q == GW'(GAP_CYCLES - 1)) begin
                    if (idx_q == 8'(NUM_REGS - 1)) begin
                        seq_d = S_DONE;
                    end else begin
                        idx_d = idx_q + 8'd1;
                        seq_d = S_START;
                    end
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: seq_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_camera_top.sv
// Bench for camera_top: table-driven control vectors plus a bus-level SCCB decoder checked against the register table.
module tb_camera_top;
  localparam int CLK_HZ = 4_000_000;
  localparam int SCL_HZ = 100_000;
  localparam int Q      = CLK_HZ / (4 * SCL_HZ);
  localparam int GAP    = 40;
  localparam int NREG   = 4;
  localparam int TXN    = 29 * 4 * Q + GAP;

  logic clk = 1'b0;
  logic rst;
  logic start;
  wire  sda_w;
  wire  scl_w;
  logic done;
  logic busy;
`ifdef ACK_CHECK_EN
  logic err;
`endif

  pullup (sda_w);
  pullup (scl_w);

  camera_top #(
    .CLK_FREQ_HZ(CLK_HZ),
    .SCL_FREQ_HZ(SCL_HZ),
    .DEV_ADDR   (8'h42),
    .NUM_REGS   (NREG),
    .GAP_CYCLES (GAP)
  ) dut (
    .Clk  (clk),
    .reset(rst),
    .start(start),
    .sda  (sda_w),
    .scl  (scl_w),
`ifdef ACK_CHECK_EN
    .err  (err),
`endif
    .done (done),
    .busy (busy)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic check_rng(input string name, input longint act, input longint lo, input longint hi);
    n_chk++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  // Reference model: the register table as written in the datasheet-level description.
  logic [15:0] ref_tab [4] = '{16'h1280, 16'h1204, 16'h40D0, 16'h1101};
  logic [7:0]  exp_q[$];

  // Bus decoder state
  logic [7:0] got_q[$];
  int         t_start[$];
  int         t_stop[$];
  int         ack_bad, per_err, bitpos, last_rise;
  logic       have_rise;
  logic [7:0] shreg;

  task automatic mon_clear();
    got_q.delete();
    t_start.delete();
    t_stop.delete();
    ack_bad   = 0;
    per_err   = 0;
    bitpos    = 0;
    have_rise = 1'b0;
  endtask

  initial begin
    logic ps, pc, s, c;
    ps = 1'b1;
    pc = 1'b1;
    forever begin
      @(negedge clk);
      s = sda_w;
      c = scl_w;
      if (c && pc && ps && !s) begin
        t_start.push_back(cyc);
        bitpos    = 0;
        have_rise = 1'b0;
      end else if (c && pc && !ps && s) begin
        t_stop.push_back(cyc);
      end
      if (c && !pc) begin
        if (have_rise && (cyc - last_rise) != 4 * Q) per_err++;
        have_rise = 1'b1;
        last_rise = cyc;
        if (bitpos < 8) begin
          shreg = {shreg[6:0], s};
          bitpos++;
        end else begin
          got_q.push_back(shreg);
          if (!s) ack_bad++;
          bitpos = 0;
        end
      end
      ps = s;
      pc = c;
    end
  end

  task automatic check_bytes(input string name);
    check({name, "_nbytes"}, got_q.size(), 3 * NREG);
    for (int i = 0; i < 3 * NREG; i++)
      if (i < got_q.size()) check($sformatf("%s_byte%0d", name, i), got_q[i], exp_q[i]);
    check({name, "_ack_released"}, ack_bad, 0);
    check({name, "_bit_period"}, per_err, 0);
    check({name, "_nstart"}, t_start.size(), NREG);
    check({name, "_nstop"}, t_stop.size(), NREG);
  endtask

  task automatic wait_done(input string name, output int took);
    took = -1;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (done) begin
        took = i + 1;
        break;
      end
    end
    if (took < 0) begin
      n_chk++;
      $display("FAIL %s: done not seen within 20000 cycles", name);
    end
  endtask

  task automatic pulse_start(input int width, output int t_edge);
    @(negedge clk);
    start  = 1'b1;
    t_edge = cyc;
    repeat (width) @(negedge clk);
    start = 1'b0;
  endtask

  typedef struct {
    logic        st;
    int unsigned n;
    logic        eb;
    logic        ed;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    int   took;
    int   t_edge;
    int   t0;

    vecs[0] = '{st: 1'b0, n: 10,  eb: 1'b0, ed: 1'b0};
    vecs[1] = '{st: 1'b1, n: 1,   eb: 1'b1, ed: 1'b0};
    vecs[2] = '{st: 1'b1, n: 200, eb: 1'b1, ed: 1'b0};
    vecs[3] = '{st: 1'b0, n: 300, eb: 1'b1, ed: 1'b0};
    vecs[4] = '{st: 1'b1, n: 20,  eb: 1'b1, ed: 1'b0};
    vecs[5] = '{st: 1'b0, n: 20,  eb: 1'b1, ed: 1'b0};

    for (int t = 0; t < NREG; t++) begin
      exp_q.push_back(8'h42);
      exp_q.push_back(ref_tab[t][15:8]);
      exp_q.push_back(ref_tab[t][7:0]);
    end

    rst   = 1'b1;
    start = 1'b0;
    mon_clear();
    repeat (10) @(negedge clk);
    check("rst_sda", sda_w, 1);
    check("rst_scl", scl_w, 1);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    mon_clear();

`ifdef ACK_CHECK_EN
    repeat (10) @(negedge clk);
    pulse_start(2, t_edge);
    wait_done("nack_run", took);
    check("nack_err", err, 1);
    check("nack_busy", busy, 0);
    check("nack_nbytes", got_q.size(), 1);
    if (got_q.size() > 0) check("nack_byte0", got_q[0], 8'h42);
    check("nack_nstop", t_stop.size(), 1);
`else
    t_edge = -1;
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].st && !start && t_edge < 0) t_edge = cyc;
      start = vecs[i].st;
      repeat (vecs[i].n) @(negedge clk);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].eb);
      check($sformatf("vec%0d_done", i), done, vecs[i].ed);
    end
    if (t_start.size() > 0) check_rng("first_start_delay", t_start[0] - t_edge, Q, Q + 3);
    else check("first_start_seen", t_start.size(), 1);

    wait_done("run1", took);
    check_rng("run1_duration", cyc - t_edge, NREG * TXN - 8, NREG * TXN + 16);
    check("run1_done", done, 1);
    check("run1_busy", busy, 0);
    check("run1_idle_sda", sda_w, 1);
    check("run1_idle_scl", scl_w, 1);
    repeat (12) @(negedge clk);
    check("run1_done_held", done, 1);
    check_bytes("run1");
    if (t_start.size() > 1 && t_stop.size() > 0)
      check_rng("gap_stop_to_start", t_start[1] - t_stop[0], 3 * Q + GAP - 2, 3 * Q + GAP + 4);

    // Restart after completion
    mon_clear();
    repeat ($urandom_range(1, 20)) @(negedge clk);
    @(negedge clk);
    start  = 1'b1;
    t_edge = cyc;
    @(negedge clk);
    check("restart_done_drop", done, 0);
    check("restart_busy", busy, 1);
    repeat ($urandom_range(0, 4)) @(negedge clk);
    start = 1'b0;
    wait_done("run2", took);
    check_bytes("run2");

    // Reset in the middle of a byte while SCL is held low
    mon_clear();
    pulse_start(2, t_edge);
    repeat ($urandom_range(8 * Q, 60 * Q)) @(negedge clk);
    t0 = 0;
    while (scl_w !== 1'b0 && t0 < 4 * Q + 4) begin
      @(negedge clk);
      t0++;
    end
    check("midrst_scl_low_before", scl_w, 0);
    check("midrst_busy_before", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_scl_released", scl_w, 1);
    check("midrst_sda_released", sda_w, 1);
    check("midrst_done", done, 0);
    check("midrst_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    mon_clear();
    pulse_start(1, t_edge);
    wait_done("after_reset", took);
    check_bytes("after_reset");

    // Randomized extra start pulses while busy must not disturb the sequence
    for (int r = 0; r < 2; r++) begin
      mon_clear();
      pulse_start($urandom_range(1, 8), t_edge);
      for (int k = 0; k < 3; k++) begin
        repeat ($urandom_range(50, 1400)) @(negedge clk);
        if (busy) begin
          start = 1'b1;
          repeat ($urandom_range(1, 4)) @(negedge clk);
          start = 1'b0;
        end
      end
      wait_done($sformatf("rand%0d", r), took);
      check_rng($sformatf("rand%0d_duration", r), cyc - t_edge, NREG * TXN - 8, NREG * TXN + 16);
      check_bytes($sformatf("rand%0d", r));
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
